// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage together with the IF/ID pipeline register. It owns
//   the program counter, presents it as the instruction-memory address, and
//   registers the returned word plus its fetch address + 8 for Decode. Decode
//   uses that PC+8 value as the R15 read value.
//
// Ports
//   clock         in   1      single clock, all state changes on rising edge
//   reset         in   1      synchronous, active-high
//   stall         in   1      hazard unit: hold PC and IF/ID contents
//   flush         in   1      hazard unit: load a bubble into IF/ID
//   branchTaken   in   1      Execute: redirect the PC to branchTarget
//   branchTarget  in   WIDTH  redirect address (low two bits ignored)
//   instrMemData  in   WIDTH  instruction memory read data for address pcF
//   pcF           out  WIDTH  current PC, drives the instruction memory
//   instrD        out  WIDTH  registered instruction for Decode
//   PCPlus8D      out  WIDTH  registered fetch address of instrD plus 8
//   validD        out  1      1 = instrD holds a fetched word, 0 = bubble
//
// Priorities
//   PC    : reset > branchTaken > stall > increment by 4
//   IF/ID : reset > flush > stall > capture
//   A redirect does not clear IF/ID by itself; the hazard unit pairs it with
//   flush when the wrong-path word must be dropped. Every output is a flop.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             branchTaken,
   input  logic [WIDTH-1:0] branchTarget,
   input  logic [WIDTH-1:0] instrMemData,
   output logic [WIDTH-1:0] pcF,
   output logic [WIDTH-1:0] instrD,
   output logic [WIDTH-1:0] PCPlus8D,
   output logic             validD
);

   localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(32'd4);
   localparam logic [WIDTH-1:0] R15_OFFSET = WIDTH'(32'd8);
   // Clears the two byte-offset bits so redirects stay word aligned.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(32'd3));

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] instr_r;
   logic [WIDTH-1:0] pc_plus8_r;
   logic             valid_r;

   logic [WIDTH-1:0] pc_plus4_s;
   logic [WIDTH-1:0] pc_plus8_s;
   logic [WIDTH-1:0] target_aligned_s;
   logic [WIDTH-1:0] pc_next_s;
   logic [WIDTH-1:0] instr_next_s;
   logic [WIDTH-1:0] pc_plus8_next_s;
   logic             valid_next_s;

   // Sequential-address and aligned-target arithmetic (wraps modulo 2^WIDTH).
   always_comb begin
      pc_plus4_s       = pc_r + PC_STEP;
      pc_plus8_s       = pc_r + R15_OFFSET;
      target_aligned_s = branchTarget & ALIGN_MASK;
   end

   // PC next-state: a redirect wins over a stall, otherwise step by one word.
   always_comb begin
      pc_next_s = pc_r;
      if (branchTaken) begin
         pc_next_s = target_aligned_s;
      end else if (stall) begin
         pc_next_s = pc_r;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end

   // IF/ID next-state: flush inserts a bubble even while stalled.
   always_comb begin
      instr_next_s    = instr_r;
      pc_plus8_next_s = pc_plus8_r;
      valid_next_s    = valid_r;
      if (flush) begin
         instr_next_s    = {WIDTH{1'b0}};
         pc_plus8_next_s = {WIDTH{1'b0}};
         valid_next_s    = 1'b0;
      end else if (stall) begin
         instr_next_s    = instr_r;
         pc_plus8_next_s = pc_plus8_r;
         valid_next_s    = valid_r;
      end else begin
         instr_next_s    = instrMemData;
         pc_plus8_next_s = pc_plus8_s;
         valid_next_s    = 1'b1;
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // IF/ID pipeline register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_r    <= {WIDTH{1'b0}};
         pc_plus8_r <= {WIDTH{1'b0}};
         valid_r    <= 1'b0;
      end else begin
         instr_r    <= instr_next_s;
         pc_plus8_r <= pc_plus8_next_s;
         valid_r    <= valid_next_s;
      end
   end

   assign pcF      = pc_r;
   assign instrD   = instr_r;
   assign PCPlus8D = pc_plus8_r;
   assign validD   = valid_r;

endmodule
